// File: rtl/l2_norm_pkg.sv
// Shared defaults, counter-width helper and vector typedefs for the squared-L2-norm engine.
package l2_norm_pkg;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_OUT_W   = 20;
    localparam int DEF_VEC_LEN = 16;

    // The sample counter must be at least one bit wide, even for single-sample vectors.
    function automatic int cnt_w(input int vec_len);
        return (vec_len > 1) ? $clog2(vec_len) : 1;
    endfunction

    typedef logic [DEF_IN_W-1:0]   sample_t;
    typedef logic [2*DEF_IN_W-1:0] square_t;
    typedef logic [DEF_OUT_W-1:0]  acc_t;

endpackage

// File: rtl/l2_square_stage.sv
// First two pipeline stages: register the sample, then register its square; valid travels alongside.
module l2_square_stage
    import l2_norm_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   a,
    input  logic              valid_in,
    output logic [2*IN_W-1:0] sq,
    output logic              v2
);

    logic [IN_W-1:0] a_q;
    logic            v1;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            v1  <= 1'b0;
            sq  <= '0;
            v2  <= 1'b0;
        end else begin
            a_q <= a;
            v1  <= valid_in;
            sq  <= (2*IN_W)'(a_q) * (2*IN_W)'(a_q);
            v2  <= v1;
        end
    end

endmodule

// File: rtl/l2_sumsq_acc.sv
// Streaming sum-of-squares over fixed-length vectors with overflow flag.
// Define L2_SATURATE_EN to clamp the accumulator at all-ones instead of wrapping.
module l2_sumsq_acc
    import l2_norm_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int VEC_LEN = DEF_VEC_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic             valid_in,
    output logic [OUT_W-1:0] f,
    output logic             valid_out,
    output logic             overflow
);

    localparam int CW = cnt_w(VEC_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN - 1);

    if (OUT_W < 2*IN_W) begin : g_bad_width
        $error("l2_sumsq_acc: OUT_W must be at least 2*IN_W");
    end
    if (VEC_LEN < 1) begin : g_bad_len
        $error("l2_sumsq_acc: VEC_LEN must be at least 1");
    end

    logic [2*IN_W-1:0] sq;
    logic              v2;

    l2_square_stage #(.IN_W(IN_W)) u_square (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .valid_in (valid_in),
        .sq       (sq),
        .v2       (v2)
    );

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W:0]   sum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;

    assign sum   = {1'b0, acc} + (OUT_W+1)'(sq);
    assign carry = sum[OUT_W];

    // Once clamped, any further nonzero square carries again, so the clamp holds to vector end.
    always_comb begin
        acc_next = sum[OUT_W-1:0];
`ifdef L2_SATURATE_EN
        if (carry) begin
            acc_next = {OUT_W{1'b1}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            f         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (v2) begin
                if (cnt == LAST_CNT) begin
                    f         <= acc_next;
                    overflow  <= ovf_acc | carry;
                    valid_out <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    cnt     <= cnt + 1'b1;
                    ovf_acc <= ovf_acc | carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_sumsq_acc.sv
// Directed bench for l2_sumsq_acc: default, narrow (VEC_LEN=4, OUT_W=17) and single-sample builds.
module tb_l2_sumsq_acc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  a0, a1, a2;
    logic        v0, v1, v2;
    logic [19:0] f0;
    logic [16:0] f1;
    logic [15:0] f2;
    logic        vo0, vo1, vo2;
    logic        ov0, ov1, ov2;

    l2_sumsq_acc dut0 (
        .clk(clk), .reset(reset), .a(a0), .valid_in(v0),
        .f(f0), .valid_out(vo0), .overflow(ov0)
    );

    l2_sumsq_acc #(.IN_W(8), .OUT_W(17), .VEC_LEN(4)) dut1 (
        .clk(clk), .reset(reset), .a(a1), .valid_in(v1),
        .f(f1), .valid_out(vo1), .overflow(ov1)
    );

    l2_sumsq_acc #(.IN_W(8), .OUT_W(16), .VEC_LEN(1)) dut2 (
        .clk(clk), .reset(reset), .a(a2), .valid_in(v2),
        .f(f2), .valid_out(vo2), .overflow(ov2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int f;
        bit ovf;
        int cyc;
    } pulse_t;

    pulse_t q0[$];
    pulse_t q1[$];
    pulse_t q2[$];
    bit     hold_watch = 1'b0;
    int     hold_bad = 0;

    // Result pulses are captured on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (hold_watch && !vo0 && q0.size() == 1 && f0 != 20'd4096) hold_bad++;
        if (vo0) q0.push_back(pulse_t'{int'(f0), ov0, cyc});
        if (vo1) q1.push_back(pulse_t'{int'(f1), ov1, cyc});
        if (vo2) q2.push_back(pulse_t'{int'(f2), ov2, cyc});
    end

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    sel;
        int    val;
        bit    incr;
        int    count;
        bit    bubbles;
        int    exp_f;
        bit    exp_ovf;
    } vec_t;

    vec_t vecs[4];

    task automatic drive(input int sel, input int val, input bit v);
        a0 = 8'h00; v0 = 1'b0;
        a1 = 8'h00; v1 = 1'b0;
        a2 = 8'h00; v2 = 1'b0;
        case (sel)
            0: begin a0 = 8'(val); v0 = v; end
            1: begin a1 = 8'(val); v1 = v; end
            default: begin a2 = 8'(val); v2 = v; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'hA5, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        drive(0, 0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        int last_cyc;
        int val;
        pulse_t p;
        doReset();
        q0.delete();
        q1.delete();
        val = vecs[idx].val;
        last_cyc = 0;
        for (int i = 0; i < vecs[idx].count; i++) begin
            last_cyc = cyc;
            drive(vecs[idx].sel, val, 1'b1);
            if (vecs[idx].bubbles) drive(vecs[idx].sel, 8'hAA, 1'b0);
            if (vecs[idx].incr) val++;
        end
        idle(6);
        if (vecs[idx].sel == 0) begin
            checkOutput({vecs[idx].name, " pulses"}, q0.size(), 1);
            if (q0.size() > 0) p = q0[0];
            else p = pulse_t'{-1, 1'b0, -1};
        end else begin
            checkOutput({vecs[idx].name, " pulses"}, q1.size(), 1);
            if (q1.size() > 0) p = q1[0];
            else p = pulse_t'{-1, 1'b0, -1};
        end
        checkOutput({vecs[idx].name, " f"}, p.f, vecs[idx].exp_f);
        checkOutput({vecs[idx].name, " overflow"}, int'(p.ovf), int'(vecs[idx].exp_ovf));
        checkOutput({vecs[idx].name, " latency"}, p.cyc - last_cyc, 3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int s_cyc[3];

        vecs[0] = '{"const3",   0,   3, 1'b0, 16, 1'b0,    144, 1'b0};
        vecs[1] = '{"const255", 0, 255, 1'b0, 16, 1'b0, 1040400, 1'b0};
`ifdef L2_SATURATE_EN
        vecs[2] = '{"narrow_ovf", 1, 255, 1'b0, 4, 1'b0, 131071, 1'b1};
`else
        vecs[2] = '{"narrow_ovf", 1, 255, 1'b0, 4, 1'b0, 129028, 1'b1};
`endif
        vecs[3] = '{"ramp_bubbles", 0, 1, 1'b1, 16, 1'b1, 1496, 1'b0};

        reset = 1'b1;
        a0 = '0; a1 = '0; a2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset f", int'(f0), 0);
        checkOutput("reset valid_out", int'(vo0), 0);
        checkOutput("reset overflow", int'(ov0), 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) applyStimulus(i);

        // Partial vector followed by reset must vanish without a pulse.
        q0.delete();
        for (int i = 0; i < 5; i++) drive(0, 2, 1'b1);
        doReset();
        checkOutput("midreset f", int'(f0), 0);
        checkOutput("midreset overflow", int'(ov0), 0);
        for (int i = 0; i < 16; i++) drive(0, 1, 1'b1);
        idle(6);
        checkOutput("midreset pulses", q0.size(), 1);
        checkOutput("midreset f_after", (q0.size() > 0) ? q0[0].f : -1, 16);
        checkOutput("midreset ovf_after", (q0.size() > 0) ? int'(q0[0].ovf) : -1, 0);

        // Back-to-back vectors with no gap.
        doReset();
        q0.delete();
        hold_bad = 0;
        hold_watch = 1'b1;
        for (int i = 0; i < 16; i++) drive(0, 16, 1'b1);
        for (int i = 0; i < 16; i++) drive(0, 1, 1'b1);
        idle(6);
        hold_watch = 1'b0;
        checkOutput("b2b pulses", q0.size(), 2);
        if (q0.size() == 2) begin
            checkOutput("b2b first f", q0[0].f, 4096);
            checkOutput("b2b second f", q0[1].f, 16);
            checkOutput("b2b spacing", q0[1].cyc - q0[0].cyc, 16);
        end
        checkOutput("b2b hold", hold_bad, 0);

        // Single-sample vectors: every accepted sample yields its own square.
        doReset();
        q2.delete();
        s_cyc[0] = cyc;
        drive(2, 3, 1'b1);
        drive(2, 99, 1'b0);
        s_cyc[1] = cyc;
        drive(2, 5, 1'b1);
        s_cyc[2] = cyc;
        drive(2, 7, 1'b1);
        idle(6);
        checkOutput("len1 pulses", q2.size(), 3);
        if (q2.size() == 3) begin
            checkOutput("len1 f0", q2[0].f, 9);
            checkOutput("len1 f1", q2[1].f, 25);
            checkOutput("len1 f2", q2[2].f, 49);
            checkOutput("len1 lat0", q2[0].cyc - s_cyc[0], 3);
            checkOutput("len1 lat2", q2[2].cyc - s_cyc[2], 3);
            checkOutput("len1 ovf", int'(q2[2].ovf), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
